// File: rtl/rgbi_color_pipe_if.sv
// Pixel, timing and LUT-programming bus for rgbi_color_pipe.
// master drives pixels and table writes; slave is the colour pipe.
interface rgbi_color_pipe_if #(
  parameter int unsigned CW = 4,
  parameter int unsigned IW = 4,
  parameter int unsigned OW = 8
);
  logic [CW-1:0]    r_in;
  logic [CW-1:0]    g_in;
  logic [CW-1:0]    b_in;
  logic [IW-1:0]    i_in;
  logic             hblank_in;
  logic             vblank_in;
  logic             hs_in;
  logic             vs_in;
  logic             lut_en;
  logic             lut_wr;
  logic [1:0]       lut_sel;
  logic [CW+IW-1:0] lut_addr;
  logic [OW-1:0]    lut_data;
  logic             ce_pix;
  logic [OW-1:0]    r_out;
  logic [OW-1:0]    g_out;
  logic [OW-1:0]    b_out;
  logic             hblank_out;
  logic             vblank_out;
  logic             hs_out;
  logic             vs_out;
  logic             de_out;

  modport master (
    output r_in, g_in, b_in, i_in, hblank_in, vblank_in, hs_in, vs_in,
           lut_en, lut_wr, lut_sel, lut_addr, lut_data,
    input  ce_pix, r_out, g_out, b_out, hblank_out, vblank_out, hs_out, vs_out, de_out
  );

  modport slave (
    input  r_in, g_in, b_in, i_in, hblank_in, vblank_in, hs_in, vs_in,
           lut_en, lut_wr, lut_sel, lut_addr, lut_data,
    output ce_pix, r_out, g_out, b_out, hblank_out, vblank_out, hs_out, vs_out, de_out
  );
endinterface

// File: rtl/rgbi_color_pipe.sv
// RGBI to wide RGB colour expander: pixel-rate divider, two tick pipeline stages,
// per-channel programmable tables with a multiply fallback, blanking and sync polarity.
module rgbi_color_pipe #(
  parameter int unsigned CW       = 4,
  parameter int unsigned IW       = 4,
  parameter int unsigned OW       = 8,
  parameter int unsigned CE_DIV   = 8,
  parameter bit          SWAP_RB  = 1'b1,
  parameter bit          SYNC_INV = 1'b1
) (
  input logic              clk_video,
  input logic              reset_n,
  rgbi_color_pipe_if.slave bus
);

  localparam int unsigned AW    = CW + IW;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned DW    = (CE_DIV > 2) ? $clog2(CE_DIV) : 1;

  // R/B bit reorder; only meaningful for 4-bit components
  function automatic logic [CW-1:0] swap_bits(input logic [CW-1:0] c);
    logic [3:0] c4;
    c4 = 4'(c);
    if (SWAP_RB && (CW == 4)) return CW'({c4[1], c4[2], c4[3], c4[0]});
    return c;
  endfunction

  // c*i scaled to OW bits: top bits when wider, zero-filled on the right when narrower
  function automatic logic [OW-1:0] arith(input logic [CW-1:0] c, input logic [IW-1:0] i);
    logic [AW-1:0]    p;
    logic [AW+OW-1:0] ext;
    p   = AW'(c) * AW'(i);
    ext = {p, {OW{1'b0}}};
    return ext[AW+OW-1 -: OW];
  endfunction

  logic [DW-1:0] div;
  logic [AW-1:0] s1_addr_r, s1_addr_g, s1_addr_b;
  logic [IW-1:0] s1_i;
  logic          s1_hb, s1_vb, s1_hs, s1_vs;
  logic [OW-1:0] res_r, res_g, res_b;
  logic [OW-1:0] lut_r [DEPTH];
  logic [OW-1:0] lut_g [DEPTH];
  logic [OW-1:0] lut_b [DEPTH];

  // pixel-rate divider; ce_pix follows the cycle in which the divider is 0
  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      div        <= '0;
      bus.ce_pix <= 1'b0;
    end else begin
      div        <= (div == DW'(CE_DIV - 1)) ? '0 : div + DW'(1);
      bus.ce_pix <= (div == '0);
    end
  end

  // S1: table addresses, intensity and timing
  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      s1_addr_r <= '0;
      s1_addr_g <= '0;
      s1_addr_b <= '0;
      s1_i      <= '0;
      s1_hb     <= 1'b0;
      s1_vb     <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
    end else if (bus.ce_pix) begin
      s1_addr_r <= {swap_bits(bus.r_in), bus.i_in};
      s1_addr_g <= {bus.g_in, bus.i_in};
      s1_addr_b <= {swap_bits(bus.b_in), bus.i_in};
      s1_i      <= bus.i_in;
      s1_hb     <= bus.hblank_in;
      s1_vb     <= bus.vblank_in;
      s1_hs     <= bus.hs_in;
      s1_vs     <= bus.vs_in;
    end
  end

  // tables keep their contents across reset; writes land on any cycle
  always_ff @(posedge clk_video) begin
    if (bus.lut_wr) begin
      if (bus.lut_sel == 2'd0 || bus.lut_sel == 2'd3) lut_r[bus.lut_addr] <= bus.lut_data;
      if (bus.lut_sel == 2'd1 || bus.lut_sel == 2'd3) lut_g[bus.lut_addr] <= bus.lut_data;
      if (bus.lut_sel == 2'd2 || bus.lut_sel == 2'd3) lut_b[bus.lut_addr] <= bus.lut_data;
    end
  end

  // asynchronous read sees pre-write contents at the capturing edge
  always_comb begin
    res_r = '0;
    res_g = '0;
    res_b = '0;
    if (!(s1_hb || s1_vb) && (s1_i != '0)) begin
      if (bus.lut_en) begin
        res_r = lut_r[s1_addr_r];
        res_g = lut_g[s1_addr_g];
        res_b = lut_b[s1_addr_b];
      end else begin
        res_r = arith(s1_addr_r[AW-1:IW], s1_i);
        res_g = arith(s1_addr_g[AW-1:IW], s1_i);
        res_b = arith(s1_addr_b[AW-1:IW], s1_i);
      end
    end
  end

  // S2: output registers
  always_ff @(posedge clk_video or negedge reset_n) begin
    if (!reset_n) begin
      bus.r_out      <= '0;
      bus.g_out      <= '0;
      bus.b_out      <= '0;
      bus.hblank_out <= 1'b0;
      bus.vblank_out <= 1'b0;
      bus.hs_out     <= SYNC_INV;
      bus.vs_out     <= SYNC_INV;
      bus.de_out     <= 1'b0;
    end else if (bus.ce_pix) begin
      bus.r_out      <= res_r;
      bus.g_out      <= res_g;
      bus.b_out      <= res_b;
      bus.hblank_out <= s1_hb;
      bus.vblank_out <= s1_vb;
      bus.hs_out     <= s1_hs ^ SYNC_INV;
      bus.vs_out     <= s1_vs ^ SYNC_INV;
      bus.de_out     <= ~(s1_hb | s1_vb);
    end
  end

endmodule
